// File: rtl/elementwise_output_packer.sv
// elementwise_output_packer: packs an int8 element stream into LANES-byte words and queues them for a valid/ready writer
module elementwise_output_packer #(
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [31:0]          i_num_elems,
    input  logic                 i_in_valid,
    input  logic [7:0]           i_in_data,
    output logic                 o_wr_valid,
    input  logic                 i_wr_ready,
    output logic [ADDR_W-1:0]    o_wr_addr,
    output logic [8*LANES-1:0]   o_wr_data,
    output logic [LANES-1:0]     o_wr_strb,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow
);
    localparam int LW = $clog2(LANES);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_base, r_widx;
    logic [31:0]          r_num, r_cnt;
    logic [LW-1:0]        r_lane;
    logic [8*LANES-1:0]   r_lane_data, w_word;
    logic [LANES-1:0]     w_strb;
    logic [ADDR_W-1:0]    r_mem_addr [FIFO_DEPTH];
    logic [8*LANES-1:0]   r_mem_data [FIFO_DEPTH];
    logic [LANES-1:0]     r_mem_strb [FIFO_DEPTH];
    logic [PW-1:0]        r_wp, r_rp;
    logic [PW:0]          r_count, w_count_nxt;
    logic                 r_done, r_overflow, w_done_nxt;
    logic                 w_start, w_acc, w_last, w_push_req, w_push, w_pop, w_drop;

    assign w_start     = i_start && r_state == IDLE;
    assign w_acc       = r_state == RUN && i_in_valid && r_cnt < r_num;
    assign w_last      = w_acc && r_cnt == r_num - 32'd1;
    assign w_push_req  = w_acc && (r_lane == LW'(LANES - 1) || w_last);
    assign w_pop       = o_wr_valid && i_wr_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still take the word
    assign w_push      = w_push_req && (r_count != (PW+1)'(FIFO_DEPTH) || w_pop);
    assign w_drop      = w_push_req && !w_push;
    assign w_count_nxt = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

    assign o_wr_valid  = r_count != '0;
    assign o_wr_addr   = o_wr_valid ? r_mem_addr[r_rp] : '0;
    assign o_wr_data   = o_wr_valid ? r_mem_data[r_rp] : '0;
    assign o_wr_strb   = o_wr_valid ? r_mem_strb[r_rp] : '0;
    assign o_busy      = r_state != IDLE;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;

    always_comb begin
        w_word = r_lane_data;
        w_word[8*r_lane +: 8] = i_in_data;
        for (int i = 0; i < LANES; i++) w_strb[i] = LW'(i) <= r_lane;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: if (i_start) begin
                w_state_nxt = i_num_elems != '0 ? RUN : IDLE;
                w_done_nxt  = i_num_elems == '0;
            end
            RUN: if (w_last) w_state_nxt = DRAIN;
            DRAIN: if (w_count_nxt == '0) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_base      <= '0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_widx      <= '0;
            r_lane      <= '0;
            r_lane_data <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            if (w_start) begin
                r_base      <= i_base_addr;
                r_num       <= i_num_elems;
                r_cnt       <= '0;
                r_widx      <= '0;
                r_lane      <= '0;
                r_lane_data <= '0;
                r_overflow  <= 1'b0;
            end else if (w_acc) begin
                r_cnt       <= r_cnt + 32'd1;
                r_lane      <= w_push_req ? '0 : r_lane + 1'b1;
                r_lane_data <= w_push_req ? '0 : w_word;
                if (w_push_req) r_widx <= r_widx + 1'b1;
                if (w_drop) r_overflow <= 1'b1;
            end
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wp] <= r_base + r_widx;
            r_mem_data[r_wp] <= w_word;
            r_mem_strb[r_wp] <= w_strb;
        end
    end
endmodule

// File: doc/elementwise_output_packer.md
# elementwise_output_packer

Downstream companion of the pipelined int8 element-wise arithmetic units (SUB/ADD element). It consumes their one-byte-per-cycle `out`/`valid` stream, which has no backpressure, packs the bytes little-endian into LANES-byte words, and buffers the words in a small FIFO. Words leave through a valid/ready write port with sequential word addresses. It also signals completion once a programmed element count has been written out.

## Interface

Parameters:
- LANES, 8: int8 elements per output word; power of two, 2..16.
- FIFO_DEPTH, 4: output word FIFO entries; power of two, ≥2.
- ADDR_W, 16: word-address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches base_addr and num_elems; honoured only in IDLE.
- base_addr  in  ADDR_W  word address of the first output word.
- num_elems  in  32  number of int8 elements in the job (unsigned).
- in_valid  in  1  element strobe (driven by the element unit's `valid`).
- in_data  in  8  signed int8 element (driven by the element unit's `out`).
- wr_valid  out  1  FIFO head word available.
- wr_ready  in  1  sink accepts the head word when wr_valid && wr_ready.
- wr_addr  out  ADDR_W  word address of the head word.
- wr_data  out  8*LANES  packed head word.
- wr_strb  out  LANES  per-byte enable of the head word.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full.

## Operation

- States:
  - IDLE: start with num_elems>0 → RUN; start with num_elems=0 → IDLE, with a done pulse the next cycle.
  - RUN: after the final element is accepted → DRAIN.
  - DRAIN: when the FIFO is empty → IDLE and done=1 for one cycle.
- Accepted element: in_valid=1 in RUN, while elem_cnt < num_elems.
  - in_valid is ignored in IDLE and DRAIN. No other side effects.
- Packing: element k of the job goes to lane k mod LANES, bits [8*lane+7 : 8*lane].
  - Bytes are stored raw; no sign extension or saturation.
- Word push: occurs when lane LANES-1 is filled or the final element is accepted.
  - The pushed word is the lane register merged with the incoming byte.
  - strb has ones for filled lanes. Unfilled lanes carry data 0 and strb 0.
  - The lane register clears after the push.
- Addressing: the word with index w gets address base_addr + w, modulo 2^ADDR_W (wraps silently).
- FIFO: first-word fall-through; wr_addr, wr_data and wr_strb are stored per entry.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
  - Pushing into a full FIFO: the word is dropped, overflow is set, and the word index still increments.
  - A simultaneous pop frees a slot, so that case is not "full".
- overflow clears only on an accepted start or on reset.
- start while busy is ignored; latched parameters are unchanged.
- Counters: elem_cnt is 32 bits, word index is ADDR_W bits, lane index is log2(LANES) bits. All clear on an accepted start.

## Timing

- Reset values: wr_valid=0, wr_addr=0, wr_data=0, wr_strb=0, busy=0, done=0, overflow=0. State is IDLE and the FIFO is empty.
- Reset asserted mid-job: everything returns to these values immediately; partial words and FIFO contents are discarded.
- busy rises the cycle after the start edge.
- Elements may arrive every cycle, starting the cycle after the start edge.
- Latency: the completing byte is sampled at edge N, and wr_valid=1 from cycle N+1 if the FIFO was empty.
- Sustained input of 1 byte/cycle yields 1 word per LANES cycles. With wr_ready=1 continuously, the FIFO never exceeds 1 entry.
- Output stability: while wr_valid=1 and wr_ready=0, wr_addr, wr_data and wr_strb hold stable.
- wr_valid does not drop until the handshake completes.
- done: fires one cycle after the handshake that empties the FIFO in DRAIN. In that same cycle busy=0.
- If the FIFO is already empty when the final element is pushed, done still follows the pop of that word.

## Test plan

- LANES=8, base_addr=0x0100, num_elems=16, in_data=0..15 on consecutive cycles, wr_ready=1:
  - word 0x0100 = 0x0706050403020100, word 0x0101 = 0x0F0E0D0C0B0A0908, both strb=0xFF.
  - Single done pulse; busy low after done.
- num_elems=11 with in_data=-1..-11:
  - second word has strb=0x07, lanes 0..2 = 0xF7, 0xF6, 0xF5, upper lanes 0.
- Stall: wr_ready=0 for 40 cycles, num_elems=32 at 1 byte/cycle, FIFO_DEPTH=4:
  - all 4 words held with head stable; no overflow.
  - Then num_elems=40 with wr_ready=0: fifth word dropped, overflow=1 and stays set until the next start.
- Gapped in_valid (1 of every 3 cycles), in_valid pulses while in IDLE/DRAIN, and a start pulse while busy:
  - stray bytes and the extra start are ignored; the output equals the ungapped reference.
- Edge cases:
  - num_elems=0: no writes, done exactly one cycle after start.
  - base_addr=0xFFFF with 3 words: addresses 0xFFFF, 0x0000, 0x0001.
- Reset pulled low mid-RUN with 2 words queued:
  - all outputs return to reset values, FIFO empty.
  - A fresh job afterwards completes correctly.
